// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the two-road junction light controller.
//   - 3-bit state codes (codes 6 and 7 are unused and recover to main green)
//   - one-hot light encodings {red,yellow,green}
//   - light-pair struct and the state-to-lights decode function
package traffic_pkg;

   localparam logic [2:0] ST_MAIN_GREEN = 3'd0;
   localparam logic [2:0] ST_MAIN_YEL   = 3'd1;
   localparam logic [2:0] ST_RED_A      = 3'd2;
   localparam logic [2:0] ST_SIDE_GREEN = 3'd3;
   localparam logic [2:0] ST_SIDE_YEL   = 3'd4;
   localparam logic [2:0] ST_RED_B      = 3'd5;

   localparam logic [2:0] LIGHT_RED = 3'b100;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b001;

   typedef struct packed {
      logic [2:0] main_l;
      logic [2:0] side_l;
   } lights_t;

   // Moore decode of a state code into the main/side light pair.
   // Unused codes show all-red, the safe display.
   function automatic lights_t decode_lights(input logic [2:0] st);
      lights_t l;
      case (st)
         ST_MAIN_GREEN: begin l.main_l = LIGHT_GRN; l.side_l = LIGHT_RED; end
         ST_MAIN_YEL:   begin l.main_l = LIGHT_YEL; l.side_l = LIGHT_RED; end
         ST_SIDE_GREEN: begin l.main_l = LIGHT_RED; l.side_l = LIGHT_GRN; end
         ST_SIDE_YEL:   begin l.main_l = LIGHT_RED; l.side_l = LIGHT_YEL; end
         default:       begin l.main_l = LIGHT_RED; l.side_l = LIGHT_RED; end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick.sv
// tick_edge_detect: turns the 1 Hz square wave into a single-cycle pulse
// on each of its rising edges, in the clk domain.
// Ports:
//   clk        - system clock
//   reset_sync - synchronous active-high reset
//   clk_1hz    - divider output square wave
//   tick       - high for one clk cycle per clk_1hz rising edge
module tick_edge_detect (
   input  logic clk,
   input  logic reset_sync,
   input  logic clk_1hz,
   output logic tick
);

   logic clk_1hz_d_r;

   // One-cycle delayed copy of clk_1hz for edge detection.
   always_ff @(posedge clk) begin
      if (reset_sync) begin
         clk_1hz_d_r <= 1'b0;
      end else begin
         clk_1hz_d_r <= clk_1hz;
      end
   end

   assign tick = clk_1hz & ~clk_1hz_d_r;

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: main/side junction sequencer. Main road rests on green;
// a latched side request runs one full side cycle once the main minimum green
// has elapsed. All durations are counted in 1 Hz ticks.
// Ports:
//   clk        - system clock (same clock as the divider)
//   reset_sync - synchronous active-high reset
//   clk_1hz    - divider output, each rising edge is one second
//   side_req   - side-road vehicle sensor, level or pulse
//   main_light - {red,yellow,green} main road, one-hot
//   side_light - {red,yellow,green} side road, one-hot
//   state_out  - current state code
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter logic [7:0] MAIN_MIN_S   = 8'd5,
   parameter logic [7:0] MAIN_YEL_S   = 8'd2,
   parameter logic [7:0] ALL_RED_S    = 8'd1,
   parameter logic [7:0] SIDE_GREEN_S = 8'd4,
   parameter logic [7:0] SIDE_YEL_S   = 8'd2
) (
   input  logic       clk,
   input  logic       reset_sync,
   input  logic       clk_1hz,
   input  logic       side_req,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic [2:0] state_out
);

   logic       tick_s;
   logic [2:0] state_r;
   logic [2:0] next_state_s;
   logic [7:0] sec_cnt_r;
   logic       req_lat_r;
   logic       enter_sg_s;
   lights_t    lights_s;
   lights_t    lights_r;

   tick_edge_detect u_tick (
      .clk        (clk),
      .reset_sync (reset_sync),
      .clk_1hz    (clk_1hz),
      .tick       (tick_s)
   );

   // Next-state logic: timed phases leave on the tick that completes their duration.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_MAIN_GREEN: begin
            // No upper limit: main green holds until a latched request and min time.
            if (tick_s && req_lat_r && (sec_cnt_r >= (MAIN_MIN_S - 8'd1))) begin
               next_state_s = ST_MAIN_YEL;
            end else begin
               next_state_s = ST_MAIN_GREEN;
            end
         end
         ST_MAIN_YEL: begin
            if (tick_s && (sec_cnt_r == (MAIN_YEL_S - 8'd1))) next_state_s = ST_RED_A;
            else next_state_s = ST_MAIN_YEL;
         end
         ST_RED_A: begin
            if (tick_s && (sec_cnt_r == (ALL_RED_S - 8'd1))) next_state_s = ST_SIDE_GREEN;
            else next_state_s = ST_RED_A;
         end
         ST_SIDE_GREEN: begin
            if (tick_s && (sec_cnt_r == (SIDE_GREEN_S - 8'd1))) next_state_s = ST_SIDE_YEL;
            else next_state_s = ST_SIDE_GREEN;
         end
         ST_SIDE_YEL: begin
            if (tick_s && (sec_cnt_r == (SIDE_YEL_S - 8'd1))) next_state_s = ST_RED_B;
            else next_state_s = ST_SIDE_YEL;
         end
         ST_RED_B: begin
            if (tick_s && (sec_cnt_r == (ALL_RED_S - 8'd1))) next_state_s = ST_MAIN_GREEN;
            else next_state_s = ST_RED_B;
         end
         default: next_state_s = ST_MAIN_GREEN;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset_sync) begin
         state_r <= ST_MAIN_GREEN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Seconds counter: restarts on every state change, saturates at 255.
   always_ff @(posedge clk) begin
      if (reset_sync) begin
         sec_cnt_r <= 8'd0;
      end else if (next_state_s != state_r) begin
         sec_cnt_r <= 8'd0;
      end else if (tick_s && (sec_cnt_r != 8'hFF)) begin
         sec_cnt_r <= sec_cnt_r + 8'd1;
      end else begin
         sec_cnt_r <= sec_cnt_r;
      end
   end

   assign enter_sg_s = (next_state_s == ST_SIDE_GREEN) && (state_r != ST_SIDE_GREEN);

   // Side request latch: the vehicle is served once side green starts, so clearing
   // on entry wins over a request seen in that same cycle.
   always_ff @(posedge clk) begin
      if (reset_sync) begin
         req_lat_r <= 1'b0;
      end else if (enter_sg_s) begin
         req_lat_r <= 1'b0;
      end else if (side_req && (state_r != ST_SIDE_GREEN)) begin
         req_lat_r <= 1'b1;
      end else begin
         req_lat_r <= req_lat_r;
      end
   end

   // Output decode from the next state, so the registered lights change on the
   // same edge as the state register.
   always_comb begin
      lights_s = decode_lights(next_state_s);
   end

   // Registered light outputs.
   always_ff @(posedge clk) begin
      if (reset_sync) begin
         lights_r.main_l <= LIGHT_GRN;
         lights_r.side_l <= LIGHT_RED;
      end else begin
         lights_r <= lights_s;
      end
   end

   assign main_light = lights_r.main_l;
   assign side_light = lights_r.side_l;
   assign state_out  = state_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl. Expected states are pushed to a
// scoreboard queue as each second is driven and popped when the DUT responds.
module tb_traffic_light_ctrl;

   logic       clk = 1'b0;
   logic       reset_sync;
   logic       clk_1hz;
   logic       side_req;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic [2:0] state_out;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [2:0] exp_q[$];
   // Expected state after each tick of one full side cycle, request pending at tick 1.
   logic [2:0] seq [16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                            3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0, 3'd0};

   traffic_light_ctrl dut (
      .clk        (clk),
      .reset_sync (reset_sync),
      .clk_1hz    (clk_1hz),
      .side_req   (side_req),
      .main_light (main_light),
      .side_light (side_light),
      .state_out  (state_out)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] exp_main(input logic [2:0] st);
      case (st)
         3'd0:    return 3'b001;
         3'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_side(input logic [2:0] st);
      case (st)
         3'd3:    return 3'b001;
         3'd4:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_state(input string tag, input logic [2:0] st);
      check_val({tag, "_state"}, state_out, st);
      check_val({tag, "_main"}, main_light, exp_main(st));
      check_val({tag, "_side"}, side_light, exp_side(st));
   endtask

   // One second: clk_1hz high for 'hold' clk cycles, checked right after the rising edge.
   task automatic tick_exp(input int hold, input logic [2:0] st, input string tag);
      logic [2:0] e;
      exp_q.push_back(st);
      @(negedge clk) clk_1hz = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      check_state(tag, e);
      repeat (hold - 1) @(negedge clk);
      clk_1hz = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_seq(input int lo, input int hi, input string tag);
      for (int i = lo; i <= hi; i++) tick_exp(((i % 3) == 0) ? 3 : 1, seq[i], tag);
   endtask

   task automatic idle_ticks(input int n, input string tag);
      for (int i = 0; i < n; i++) tick_exp(1, 3'd0, tag);
   endtask

   task automatic pulse_req();
      @(negedge clk) side_req = 1'b1;
      @(negedge clk) side_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) reset_sync = 1'b1;
      @(negedge clk) reset_sync = 1'b0;
      check_state("reset", 3'd0);
   endtask

   initial begin
      reset_sync = 1'b1;
      clk_1hz    = 1'b0;
      side_req   = 1'b0;
      // Reset held for three cycles, then released.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_state("rst_hold", 3'd0);
      end
      reset_sync = 1'b0;
      @(negedge clk);
      check_state("rst_rel", 3'd0);

      // No request: main green holds.
      idle_ticks(20, "idle");

      // Request arriving with a tick is not acted on until the following tick.
      @(negedge clk);
      side_req = 1'b1;
      clk_1hz  = 1'b1;
      exp_q.push_back(3'd0);
      @(negedge clk);
      check_state("same_tick", exp_q.pop_front());
      side_req = 1'b0;
      clk_1hz  = 1'b0;
      @(negedge clk);
      tick_exp(1, 3'd1, "next_tick");
      run_seq(5, 15, "same_rest");

      // Full side cycle; first second held high 10 cycles must count once.
      do_reset();
      pulse_req();
      tick_exp(10, seq[0], "long_high");
      run_seq(1, 15, "seq");

      // Reset coinciding with a tick: tick lost, counting restarts from zero.
      do_reset();
      pulse_req();
      idle_ticks(3, "pre_rst");
      @(negedge clk);
      reset_sync = 1'b1;
      clk_1hz    = 1'b1;
      @(negedge clk);
      reset_sync = 1'b0;
      clk_1hz    = 1'b0;
      check_state("rst_tick", 3'd0);
      @(negedge clk);
      pulse_req();
      run_seq(0, 15, "after_rst_tick");

      // Reset in main green clears a pending request.
      do_reset();
      pulse_req();
      idle_ticks(2, "pend");
      do_reset();
      idle_ticks(10, "req_cleared");

      // Reset during side green, with a request raised in the reset cycle.
      do_reset();
      pulse_req();
      run_seq(0, 7, "to_sg");
      @(negedge clk);
      reset_sync = 1'b1;
      side_req   = 1'b1;
      @(negedge clk);
      reset_sync = 1'b0;
      side_req   = 1'b0;
      check_state("rst_sg", 3'd0);
      idle_ticks(20, "rst_sg_hold");

      // Request only during side green gives no second cycle.
      do_reset();
      pulse_req();
      run_seq(0, 7, "sg_req");
      pulse_req();
      run_seq(8, 15, "sg_req");
      idle_ticks(10, "no_second");

      // Request during side yellow: new cycle MAIN_MIN_S ticks after main green returns.
      do_reset();
      pulse_req();
      run_seq(0, 11, "sy_req");
      pulse_req();
      run_seq(12, 14, "sy_req");
      run_seq(0, 15, "second_cycle");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Consumes the 1 Hz square wave from the clock divider and sequences a two-road (main/side) junction light controller.
- Main road rests on green. A latched side-road vehicle request triggers one full side cycle once the main-road minimum green has elapsed.
- All timing is counted in whole seconds, using rising edges of clk_1hz detected in the fast clock domain.

Parameters:
- MAIN_MIN_S, 8'd5, minimum main green in seconds (>=1)
- MAIN_YEL_S, 8'd2, main yellow in seconds (>=1)
- ALL_RED_S, 8'd1, all-red clearance in seconds, used after each yellow (>=1)
- SIDE_GREEN_S, 8'd4, side green in seconds (>=1)
- SIDE_YEL_S, 8'd2, side yellow in seconds (>=1)

Ports:
- clk  input  1  system clock, same clock that drives the divider
- reset_sync  input  1  synchronous, active-high reset
- clk_1hz  input  1  divider output, square wave; each rising edge is one second
- side_req  input  1  side-road vehicle sensor, level or single-cycle pulse
- main_light  output  3  {red,yellow,green} for the main road, one-hot
- side_light  output  3  {red,yellow,green} for the side road, one-hot
- state_out  output  3  current state encoding, for debug/bench

Behaviour:
- Clocking and reset: one clock, clk. reset_sync is synchronous and active-high. All state changes happen on posedge clk.
- Tick detection:
  - clk_1hz_d is a register of clk_1hz; its reset value is 0.
  - tick = clk_1hz & ~clk_1hz_d, evaluated combinationally.
  - Exactly one tick per rising edge, however long clk_1hz stays high.
- State encodings: MAIN_GREEN=0, MAIN_YEL=1, RED_A=2, SIDE_GREEN=3, SIDE_YEL=4, RED_B=5. Codes 6 and 7 are illegal and go to MAIN_GREEN on the next clk.
- Outputs are a Moore decode of the state register. They update in the same cycle the state register changes, with no extra latency.
  - MAIN_GREEN: main_light 001, side_light 100
  - MAIN_YEL: main_light 010, side_light 100
  - RED_A, RED_B: main_light 100, side_light 100
  - SIDE_GREEN: main_light 100, side_light 001
  - SIDE_YEL: main_light 100, side_light 010
- Reset values: state MAIN_GREEN, main_light 001, side_light 100, state_out 0, sec_cnt 0, req_lat 0, clk_1hz_d 0.
- sec_cnt (8 bit):
  - Cleared on every state transition and on reset.
  - Otherwise increments by 1 on each tick, saturating at 255 (no wrap).
- Timed transitions, for a state with duration D: at the posedge where tick=1 and sec_cnt==D-1, move to the next state.
  - MAIN_YEL uses MAIN_YEL_S and goes to RED_A.
  - RED_A uses ALL_RED_S and goes to SIDE_GREEN.
  - SIDE_GREEN uses SIDE_GREEN_S and goes to SIDE_YEL.
  - SIDE_YEL uses SIDE_YEL_S and goes to RED_B.
  - RED_B uses ALL_RED_S and goes to MAIN_GREEN.
- MAIN_GREEN exit: at a posedge where tick=1, req_lat=1 and sec_cnt>=MAIN_MIN_S-1, go to MAIN_YEL. Otherwise stay, with no upper limit.
- req_lat:
  - Set on any cycle with side_req=1 while the state is not SIDE_GREEN. The cycle of transition into SIDE_GREEN counts as not SIDE_GREEN, but clear wins.
  - Cleared on the transition into SIDE_GREEN.
  - side_req is ignored while in SIDE_GREEN, because that vehicle is being served.
- Simultaneous reset and tick: reset wins. The tick is lost and sec_cnt=0.
- Reset mid-operation: from any state, the next clk gives MAIN_GREEN and clears the pending request.
- A tick arriving in the same cycle as side_req in MAIN_GREEN does not exit on that tick (req_lat is registered). The exit happens on the next qualifying tick.
- Derived timing: side cycle length is MAIN_YEL_S + ALL_RED_S + SIDE_GREEN_S + SIDE_YEL_S + ALL_RED_S ticks.

Decomposition:
- Package traffic_pkg holds:
  - state localparams (3 bit)
  - light encodings LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001
- One sub-module, tick_edge_detect (clk, reset_sync, clk_1hz, tick). It is a registered delay plus a rising-edge AND.

Test Plan:
- Reset held 3 cycles, clk_1hz=0 -> main_light=001, side_light=100, state_out=0 throughout and after release.
- No side_req, 20 ticks -> state_out stays 0, main_light stays 001.
- side_req pulsed 1 cycle before the first tick, defaults -> exits on tick 5. Then MAIN_YEL for ticks 5..6, RED_A for tick 7, SIDE_GREEN for ticks 8..11, SIDE_YEL for ticks 12..13, RED_B for tick 14, MAIN_GREEN from tick 15.
- clk_1hz held high for 10 clk cycles, then low -> sec_cnt advances by exactly 1.
- reset_sync asserted for 1 cycle during SIDE_GREEN -> next cycle state_out=0, main_light=001, req_lat=0. With no further request, MAIN_GREEN holds for 20 ticks.
- side_req asserted only during SIDE_GREEN, plus a second request during SIDE_YEL -> the first causes no second cycle. The second causes a new side cycle exactly MAIN_MIN_S ticks after re-entering MAIN_GREEN.
